shared_port_sched: RTL and testbench

- Sequential lock-style scheduler that shares one downstream resource port (e.g. event-queue access) between NR requesters.
- A granted requester owns the port across multiple cycles until it releases, drops its request, or is pre-empted by the hold timeout.
- Next owner is chosen round-robin, with zero-bubble handoff between owners.
- Sits between the per-core request lines and the shared resource mux; gnt_e drives the mux select.

---
 rtl/shared_port_sched_pkg.sv | 18 +
 rtl/shared_port_sched_rr_pick.sv | 39 +++
 rtl/shared_port_sched.sv | 140 ++++++++++++++
 tb/tb_shared_port_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_port_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_port_sched_pkg
// Brief    : State encoding and index-width helper for shared_port_sched.
// Revision : 1.0
// ============================================================================
package shared_port_sched_pkg;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_own  = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shared_port_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : shared_port_sched_rr_pick
// Brief    : Combinational masked round-robin picker, scanning from last+1.
// Revision : 1.0
// ============================================================================
module shared_port_sched_rr_pick
    import shared_port_sched_pkg::*;
#(
    parameter int NR = 4,
    parameter int IW = idx_width(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [NR-1:0] mask,
    input  logic [IW-1:0] last,
    output logic [NR-1:0] onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [NR-1:0] w_cand;

    assign w_cand = req & ~mask;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 1; i <= NR; i++) begin
            if (!valid && w_cand[IW'((int'(last) + i) % NR)]) begin
                valid                               = 1'b1;
                idx                                 = IW'((int'(last) + i) % NR);
                onehot[IW'((int'(last) + i) % NR)]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shared_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : shared_port_sched
// Brief    : Round-robin lock scheduler sharing one port among NR requesters.
//            Hold-limit pre-emption is built only with SCHED_HOLD_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module shared_port_sched
    import shared_port_sched_pkg::*;
#(
    parameter int NR       = 4,
    parameter int MAX_HOLD = 16,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NR-1:0]          req,
    input  logic [NR-1:0]          rel,
    input  logic                   stall,
    output logic [NR-1:0]          gnt_v,
    output logic [$clog2(NR)-1:0]  gnt_e,
    output logic                   gnt_val,
    output logic                   timeout
);

    localparam int IW = idx_width(NR);

    logic [0:0]    r_state;
    logic [NR-1:0] r_gnt_v;
    logic [IW-1:0] r_gnt_e;
    logic [IW-1:0] r_last;
    logic          r_gnt_val;
    logic          r_timeout;

    logic          w_own;
    logic [NR-1:0] w_mask;
    logic [IW-1:0] w_pick_last;
    logic [NR-1:0] w_pick_oh;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_val;
    logic          w_rel_own;
    logic          w_req_own;
    logic          w_others;
    logic          w_limit;
    logic          w_end;
    logic          w_to;

    assign w_own = (r_state == c_st_own);

    // While owning, the same picker serves the handoff: owner masked, scan from owner+1.
    assign w_mask      = w_own ? r_gnt_v : '0;
    assign w_pick_last = w_own ? r_gnt_e : r_last;

    shared_port_sched_rr_pick #(
        .NR (NR),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .mask   (w_mask),
        .last   (w_pick_last),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .valid  (w_pick_val)
    );

    assign w_rel_own = |(rel & r_gnt_v);
    assign w_req_own = |(req & r_gnt_v);
    assign w_others  = |(req & ~r_gnt_v);
    assign w_end     = w_rel_own | ~w_req_own | w_limit;
    assign w_to      = w_limit & ~w_rel_own & w_req_own;

`ifdef SCHED_HOLD_TIMEOUT_EN
    localparam logic [CW-1:0] c_hold_last = CW'(MAX_HOLD - 1);

    logic [CW-1:0] r_hold_cnt;

    assign w_limit = w_own && w_others && (r_hold_cnt == c_hold_last);

    // Counts only while a competitor waits; cleared on any ownership change.
    always_ff @(posedge clk) begin
        if (reset || !w_own || w_end) begin
            r_hold_cnt <= '0;
        end else if (w_others && (r_hold_cnt != c_hold_last)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    logic w_unused_hold;

    assign w_limit       = 1'b0;
    // Keeps the hold-limit parameters referenced when the limit is compiled out.
    assign w_unused_hold = ^CW'(MAX_HOLD);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_gnt_v   <= '0;
            r_gnt_e   <= '0;
            r_gnt_val <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= IW'(NR - 1);
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!stall && w_pick_val) begin
                        r_state   <= c_st_own;
                        r_gnt_v   <= w_pick_oh;
                        r_gnt_e   <= w_pick_idx;
                        r_gnt_val <= 1'b1;
                    end
                end
                c_st_own: begin
                    if (w_end) begin
                        r_last    <= r_gnt_e;
                        r_timeout <= w_to;
                        if (!stall && w_pick_val) begin
                            r_gnt_v <= w_pick_oh;
                            r_gnt_e <= w_pick_idx;
                        end else begin
                            r_state   <= c_st_idle;
                            r_gnt_v   <= '0;
                            r_gnt_e   <= '0;
                            r_gnt_val <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign gnt_v   = r_gnt_v;
    assign gnt_e   = r_gnt_e;
    assign gnt_val = r_gnt_val;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_shared_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_port_sched
// Brief    : Directed and random checks of shared_port_sched against a model.
// Revision : 1.0
// ============================================================================
module tb_shared_port_sched;

    localparam int NR       = 4;
    localparam int MAX_HOLD = 16;
`ifdef SCHED_HOLD_TIMEOUT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] rel;
    logic          stall;
    logic [NR-1:0] gnt_v;
    logic [1:0]    gnt_e;
    logic          gnt_val;
    logic          timeout;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: owner index or -1 when idle.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_to;

    shared_port_sched #(
        .NR       (NR),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .rel     (rel),
        .stall   (stall),
        .gnt_v   (gnt_v),
        .gnt_e   (gnt_e),
        .gnt_val (gnt_val),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_from(input logic [NR-1:0] r, input int excl, input int from);
        for (int k = 1; k <= NR; k++) begin
            if (r[(from + k) % NR] && (((from + k) % NR) != excl)) return (from + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit others, lim, done;
        if (reset) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_hold  = 0;
            m_to    = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (!stall && (req != '0)) begin
                m_owner = rr_from(req, -1, m_last);
                m_hold  = 0;
            end
        end else begin
            others = 1'b0;
            for (int k = 0; k < NR; k++) if (k != m_owner && req[k]) others = 1'b1;
            lim  = HOLD_EN && others && (m_hold == MAX_HOLD - 1);
            done = rel[m_owner] || !req[m_owner] || lim;
            if (done) begin
                m_to   = lim && !rel[m_owner] && req[m_owner];
                m_last = m_owner;
                m_hold = 0;
                m_owner = (!stall && others) ? rr_from(req, m_owner, m_owner) : -1;
            end else if (others && m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt_v",   gnt_v,   (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("gnt_e",   gnt_e,   (m_owner >= 0) ? m_owner : 0);
        chk("gnt_val", gnt_val, (m_owner >= 0) ? 1 : 0);
        chk("timeout", timeout, m_to);
    endtask

    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic s, input logic rs);
        @(negedge clk);
        req   = r;
        rel   = l;
        stall = s;
        reset = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [NR-1:0] r;
        logic [NR-1:0] l;
        logic          s;
        logic          rs;
        int            to_seen;

        req = '0; rel = '0; stall = 1'b0; reset = 1'b1;
        m_owner = -1; m_last = NR - 1; m_hold = 0; m_to = 1'b0;

        // Reset, first grant, zero-gap handoff on release.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("reset_val", gnt_val, 0);
        step(4'b0110, 4'b0000, 1'b0, 1'b0);
        chk("first_gnt_e", gnt_e, 1);
        chk("first_gnt_v", gnt_v, 4'b0010);
        step(4'b0110, 4'b0010, 1'b0, 1'b0);
        chk("handoff_e", gnt_e, 2);
        chk("handoff_val", gnt_val, 1);

        // Lone owner keeps the port indefinitely.
        to_seen = 0;
        for (int c = 0; c < 100; c++) begin
            step(4'b0100, 4'b0000, 1'b0, 1'b0);
            if (timeout) to_seen++;
        end
        chk("lone_owner_e", gnt_e, 2);
        chk("lone_owner_to", to_seen, 0);

        // Hold-limit pre-emption.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < MAX_HOLD - 1; c++) step(4'b1001, 4'b0000, 1'b0, 1'b0);
        chk("pre_hold_e", gnt_e, 0);
        step(4'b1001, 4'b0000, 1'b0, 1'b0);
        chk("preempt_e", gnt_e, HOLD_EN ? 3 : 0);
        chk("preempt_to", timeout, HOLD_EN ? 1 : 0);
        step(4'b1001, 4'b0000, 1'b0, 1'b0);
        chk("preempt_to_clr", timeout, 0);

        // Stall blocks new grants but never revokes the owner.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("stall_idle", gnt_val, 0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("unstall_e", gnt_e, 0);
        chk("unstall_val", gnt_val, 1);
        step(4'b1111, 4'b0001, 1'b1, 1'b0);
        chk("stall_end_v", gnt_v, 0);

        // Fairness: 0,1,2,3,0, with a non-owner release ignored.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 4'b0100, 1'b0, 1'b0);
        chk("nonowner_rel", gnt_e, 0);
        for (int k = 0; k < NR; k++) begin
            step(4'b1111, 4'(1 << gnt_e), 1'b0, 1'b0);
            chk("rr_order", gnt_e, (k + 1) % NR);
            step(4'b1111, 4'b0000, 1'b0, 1'b0);
        end

        // Reset while owner 1 holds.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk("owner1", gnt_e, 1);
        step(4'b0011, 4'b0000, 1'b0, 1'b1);
        chk("mid_reset_v", gnt_v, 0);
        chk("mid_reset_to", timeout, 0);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("post_reset_e", gnt_e, 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            r = req;
            for (int b = 0; b < NR; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            l  = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
            s  = ($urandom_range(7) == 0);
            rs = ($urandom_range(499) == 0);
            step(r, l, s, rs);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
